// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock period meter.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meter_state_e;

  localparam int unsigned DEFAULT_WIDTH = 32'd31;

  // A divider with terminal count F toggles every F+1 cycles, so a full period is 2*(F+1).
  function automatic int unsigned divider_period(input int unsigned final_count);
    return 32'd2 * (final_count + 32'd1);
  endfunction

  localparam int unsigned DEFAULT_EXPECTED = divider_period(32'd20000);

endpackage

// File: rtl/clk_period_meter_sync_edge_detect.sv
// Two-flop synchroniser plus a delay flop; rise pulses for one cycle per rising edge of d.
module sync_edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchroniser chain and edge-history flop
  always_ff @(posedge clk_in) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous signal in clk_in cycles, with timeout.
// Optional lock detection is built when CLK_PERIOD_METER_LOCK_DETECT_EN is defined.
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned TIMEOUT  = 32'd1000000,
  parameter int unsigned EXPECTED = DEFAULT_EXPECTED,
  parameter int unsigned TOL      = 32'd2,
  parameter int unsigned LOCK_CNT = 32'd4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic             period_valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] ZERO_C    = {WIDTH{1'b0}};

  if ((64'(TIMEOUT) >= (64'd1 << WIDTH)) || (LOCK_CNT == 32'd0) ||
      ((64'(EXPECTED) + 64'(TOL)) >= (64'd1 << WIDTH))) begin : g_param_check
    $error("clk_period_meter: TIMEOUT/EXPECTED+TOL must fit in WIDTH and LOCK_CNT must be nonzero");
  end

  meter_state_e     state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic             timeout_q;
  logic             rise_s;

  sync_edge_detect u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (sig_in),
    .rise   (rise_s)
  );

  // Measurement FSM; arming loads count=1 so ARM times out TIMEOUT cycles after en
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= ZERO_C;
      period_q       <= ZERO_C;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else if (!en) begin
      state_q        <= IDLE;
      count_q        <= ZERO_C;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= ARM;
          count_q <= ONE_C;
        end
        ARM: begin
          if (rise_s) begin
            state_q <= MEASURE;
            count_q <= ONE_C;
          end else if (count_q == TIMEOUT_C) begin
            timeout_q <= 1'b1;
            count_q   <= ZERO_C;
          end else begin
            count_q <= count_q + ONE_C;
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle still yields a valid measurement.
          if (rise_s) begin
            period_q       <= count_q;
            period_valid_q <= 1'b1;
            timeout_q      <= 1'b0;
            count_q        <= ONE_C;
          end else if (count_q == TIMEOUT_C) begin
            timeout_q <= 1'b1;
            count_q   <= ZERO_C;
            state_q   <= ARM;
          end else begin
            count_q <= count_q + ONE_C;
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= ZERO_C;
        end
      endcase
    end
  end

  assign period_out   = period_q;
  assign period_valid = period_valid_q;
  assign timeout      = timeout_q;

`ifdef CLK_PERIOD_METER_LOCK_DETECT_EN
  localparam int unsigned       LCW    = $clog2(LOCK_CNT + 32'd1);
  localparam logic [LCW-1:0]    LOCK_C = LCW'(LOCK_CNT);
  localparam logic [WIDTH:0]    LO_C   = (EXPECTED > TOL) ? (WIDTH + 1)'(EXPECTED - TOL) : {(WIDTH + 1){1'b0}};
  localparam logic [WIDTH:0]    HI_C   = (WIDTH + 1)'(EXPECTED + TOL);

  logic [LCW-1:0] match_q;
  logic [LCW-1:0] match_d;
  logic           locked_q;
  logic           locked_d;
  logic           valid_evt_s;
  logic           tmo_evt_s;
  logic           in_tol_s;

  // Lock qualification evaluated on the same cycle the FSM publishes a measurement
  always_comb begin
    valid_evt_s = en && (state_q == MEASURE) && rise_s;
    tmo_evt_s   = en && !rise_s && (count_q == TIMEOUT_C) &&
                  ((state_q == ARM) || (state_q == MEASURE));
    in_tol_s    = ({1'b0, count_q} >= LO_C) && ({1'b0, count_q} <= HI_C);
    match_d     = match_q;
    locked_d    = locked_q;
    if (!en || tmo_evt_s) begin
      match_d  = {LCW{1'b0}};
      locked_d = 1'b0;
    end else if (valid_evt_s) begin
      if (in_tol_s) begin
        if (match_q != LOCK_C) begin
          match_d = match_q + LCW'(1'b1);
        end else begin
          match_d = match_q;
        end
        locked_d = (match_d == LOCK_C);
      end else begin
        match_d  = {LCW{1'b0}};
        locked_d = 1'b0;
      end
    end else begin
      match_d  = match_q;
      locked_d = locked_q;
    end
  end

  // Lock state registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      match_q  <= {LCW{1'b0}};
      locked_q <= 1'b0;
    end else begin
      match_q  <= match_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule
